// File: rtl/cb_map_pkg.sv
// -----------------------------------------------------------------------------
// cb_map_pkg
//   Shared definitions for the CB port-A read-data router:
//   - destination codes carried on req_dst
//   - direction (lane mapping) codes carried on req_dir
//   - NL capture FSM state encodings
//   - bit positions inside the per-destination out_valid vector
//   - sequence numbers that drive the NL capture steps
//   - helper that derives the landmark-pair index width from the lane count
// -----------------------------------------------------------------------------
package cb_map_pkg;

    typedef enum logic [2:0] {
        DST_IDLE = 3'b000,
        DST_A    = 3'b001,
        DST_B    = 3'b010,
        DST_M    = 3'b011,
        DST_TB   = 3'b100,
        DST_RSV5 = 3'b101,
        DST_RSV6 = 3'b110,
        DST_NL   = 3'b111
    } dst_e;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_POS  = 2'b01,
        DIR_NEG  = 2'b10,
        DIR_NEW  = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        NL_IDLE = 2'b00,
        NL_X    = 2'b01,
        NL_Y    = 2'b10
    } nl_state_e;

    // Bit positions inside out_valid = {TB, M, B, A}
    localparam int OV_A  = 0;
    localparam int OV_B  = 1;
    localparam int OV_M  = 2;
    localparam int OV_TB = 3;

    // Sequence counts at which the NL capture steps happen
    localparam int NL_SEQ_X = 3;
    localparam int NL_SEQ_Y = 4;
    localparam int NL_SEQ_T = 5;

    // Landmark-pair index width: max(1, log2(lanes/2))
    function automatic int lk_width(input int lanes);
        int w;
        w = $clog2(lanes / 2);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// -----------------------------------------------------------------------------
// ctrl_delay_line
//   Fixed-latency shift register that carries the request control word
//   alongside the CB read so it arrives in the same cycle as the read data.
//
// Parameters
//   WIDTH   width of the control word
//   RD_LAT  number of register stages (equals the CB read latency, 1..7)
//
// Ports
//   clk        in   clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset, clears every stage
//   i_data     in   control word captured this cycle
//   o_data     out  control word captured RD_LAT cycles earlier
// -----------------------------------------------------------------------------
module ctrl_delay_line #(
    parameter int WIDTH  = 8,
    parameter int RD_LAT = 2
) (
    input  logic             clk,
    input  logic             sys_rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [RD_LAT];

    // NOTE: every stage is cleared on reset (unlike a RAM) because the valid
    //       bit travels in here and an in-flight request must be discarded.
    // NOTE: state uses non-blocking assignments so all stages shift on the
    //       same edge without depending on statement order.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < RD_LAT; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[RD_LAT-1];

endmodule

// File: rtl/cb_douta_router.sv
// -----------------------------------------------------------------------------
// cb_douta_router
//   Routes CB port-A read data to the A/B/M/TB consumers with a per-request
//   lane mapping, and captures the NL landmark values through a small FSM.
//   The request control is delayed by RD_LAT cycles to line up with CB_douta;
//   every output is registered, so results appear RD_LAT+1 cycles after issue.
//
// Parameters
//   L           CB lane count (power of two, >= 4)
//   RSA_DW      lane width
//   SEQ_CNT_DW  sequence counter width
//   RD_LAT      CB read latency in cycles (1..7)
//   LK_DW       derived landmark-pair index width, max(1, log2(L/2))
//
// Ports
//   clk, sys_rst_n               clock / asynchronous active-low reset
//   req_valid                    CB port-A read issued this cycle
//   req_dst [2:0]                destination code (dst_e)
//   req_dir [1:0]                lane-mapping code (dir_e)
//   req_lk  [LK_DW-1:0]          landmark number, low bits
//   req_seq [SEQ_CNT_DW-1:0]     sequence count at issue
//   CB_douta [L*RSA_DW-1:0]      CB read data, RD_LAT cycles after issue
//   A/B/M/TB_douta               mapped lane buses, zero when not selected
//   out_valid [3:0]              per-destination valid {TB, M, B, A}
//   xk, yk, xita, lkx, lky       NL capture registers
//   nl_done                      one-cycle pulse when an NL capture completes
//   sel_err                      sticky flag for reserved destination codes
// -----------------------------------------------------------------------------
module cb_douta_router
    import cb_map_pkg::*;
#(
    parameter  int L          = 4,
    parameter  int RSA_DW     = 32,
    parameter  int SEQ_CNT_DW = 10,
    parameter  int RD_LAT     = 2,
    localparam int LK_DW      = lk_width(L)
) (
    input  logic                  clk,
    input  logic                  sys_rst_n,
    input  logic                  req_valid,
    input  logic [2:0]            req_dst,
    input  logic [1:0]            req_dir,
    input  logic [LK_DW-1:0]      req_lk,
    input  logic [SEQ_CNT_DW-1:0] req_seq,
    input  logic [L*RSA_DW-1:0]   CB_douta,
    output logic [L*RSA_DW-1:0]   A_douta,
    output logic [L*RSA_DW-1:0]   B_douta,
    output logic [L*RSA_DW-1:0]   M_douta,
    output logic [L*RSA_DW-1:0]   TB_douta,
    output logic [3:0]            out_valid,
    output logic [RSA_DW-1:0]     xk,
    output logic [RSA_DW-1:0]     yk,
    output logic [RSA_DW-1:0]     xita,
    output logic [RSA_DW-1:0]     lkx,
    output logic [RSA_DW-1:0]     lky,
    output logic                  nl_done,
    output logic                  sel_err
);

    localparam int CTRL_W = 1 + 3 + 2 + LK_DW + SEQ_CNT_DW;

    // -------------------------------------------------------------------------
    // Control alignment with the CB read data
    // -------------------------------------------------------------------------
    logic [CTRL_W-1:0]     w_ctrl_in;
    logic [CTRL_W-1:0]     w_ctrl_al;
    logic                  w_al_valid;
    logic [2:0]            w_al_dst_raw;
    logic [1:0]            w_al_dir_raw;
    logic [LK_DW-1:0]      w_al_lk;
    logic [SEQ_CNT_DW-1:0] w_al_seq;
    dst_e                  w_al_dst;
    dir_e                  w_al_dir;
    int                    w_seq_int;

    assign w_ctrl_in = {req_valid, req_dst, req_dir, req_lk, req_seq};

    ctrl_delay_line #(
        .WIDTH  (CTRL_W),
        .RD_LAT (RD_LAT)
    ) u_ctrl_delay_line (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .i_data    (w_ctrl_in),
        .o_data    (w_ctrl_al)
    );

    assign {w_al_valid, w_al_dst_raw, w_al_dir_raw, w_al_lk, w_al_seq} = w_ctrl_al;
    assign w_al_dst  = dst_e'(w_al_dst_raw);
    assign w_al_dir  = dir_e'(w_al_dir_raw);
    assign w_seq_int = int'(w_al_seq);

    // -------------------------------------------------------------------------
    // Lane split and landmark pair selection
    // -------------------------------------------------------------------------
    logic [RSA_DW-1:0] w_cb_lane [L];
    logic [LK_DW-1:0]  w_pair;
    logic [RSA_DW-1:0] w_lo;
    logic [RSA_DW-1:0] w_hi;

    for (genvar g = 0; g < L; g++) begin : g_lane
        assign w_cb_lane[g] = CB_douta[g*RSA_DW +: RSA_DW];
    end

    // (lk - 1) mod (L/2): L/2 is exactly 2^LK_DW, so the wrap of the
    // LK_DW-bit subtraction is the modulo.
    assign w_pair = w_al_lk - LK_DW'(1);
    assign w_lo   = w_cb_lane[{w_pair, 1'b0}];
    assign w_hi   = w_cb_lane[{w_pair, 1'b1}];

    // -------------------------------------------------------------------------
    // Lane mapping for A/B/M and for TB
    // -------------------------------------------------------------------------
    logic [L*RSA_DW-1:0] w_map_abm;
    logic [L*RSA_DW-1:0] w_map_tb;

    // NOTE: every always_comb output gets a default first, so no path through
    //       the case/if tree can leave it unassigned and infer a latch.
    always_comb begin
        w_map_abm = '0;
        case (w_al_dir)
            DIR_POS: w_map_abm = CB_douta;
            DIR_NEG: begin
                for (int i = 0; i < L; i++) begin
                    w_map_abm[i*RSA_DW +: RSA_DW] = w_cb_lane[L-1-i];
                end
            end
            DIR_NEW: begin
                w_map_abm[0      +: RSA_DW] = w_lo;
                w_map_abm[RSA_DW +: RSA_DW] = w_hi;
            end
            default: ;
        endcase
    end

    // TB walks the landmark pair across the lanes as seq advances:
    // lo sits at lane s-1 and hi trails it at lane s-2; at s=0 hi wraps
    // to the top lane, and past s=L nothing is shown.
    always_comb begin
        w_map_tb = '0;
        if (w_al_dir == DIR_NEW) begin
            for (int i = 0; i < L; i++) begin
                if (w_seq_int == i + 1) begin
                    w_map_tb[i*RSA_DW +: RSA_DW] = w_lo;
                end else if ((i <= L - 2) && (w_seq_int == i + 2)) begin
                    w_map_tb[i*RSA_DW +: RSA_DW] = w_hi;
                end
            end
            if (w_seq_int == 0) begin
                w_map_tb[(L-1)*RSA_DW +: RSA_DW] = w_hi;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Destination decode (reserved codes hit nothing and raise sel_err)
    // -------------------------------------------------------------------------
    logic w_hit_a;
    logic w_hit_b;
    logic w_hit_m;
    logic w_hit_tb;
    logic w_nl_req;
    logic w_rsv_req;

    assign w_hit_a   = w_al_valid && (w_al_dst == DST_A);
    assign w_hit_b   = w_al_valid && (w_al_dst == DST_B);
    assign w_hit_m   = w_al_valid && (w_al_dst == DST_M);
    assign w_hit_tb  = w_al_valid && (w_al_dst == DST_TB);
    assign w_nl_req  = w_al_valid && (w_al_dst == DST_NL);
    assign w_rsv_req = w_al_valid && ((w_al_dst == DST_RSV5) || (w_al_dst == DST_RSV6));

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            A_douta   <= '0;
            B_douta   <= '0;
            M_douta   <= '0;
            TB_douta  <= '0;
            out_valid <= '0;
            sel_err   <= 1'b0;
        end else begin
            A_douta          <= w_hit_a  ? w_map_abm : '0;
            B_douta          <= w_hit_b  ? w_map_abm : '0;
            M_douta          <= w_hit_m  ? w_map_abm : '0;
            TB_douta         <= w_hit_tb ? w_map_tb  : '0;
            out_valid[OV_A]  <= w_hit_a;
            out_valid[OV_B]  <= w_hit_b;
            out_valid[OV_M]  <= w_hit_m;
            out_valid[OV_TB] <= w_hit_tb;
            if (w_rsv_req) begin
                sel_err <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // NL capture FSM
    //   seq 3 (any state) -> capture xk, go NL_X
    //   seq 4 in NL_X     -> capture yk/lkx, go NL_Y
    //   seq 5 in NL_Y     -> capture xita/lky, pulse nl_done, go NL_IDLE
    //   any other NL request aborts to NL_IDLE; non-NL cycles leave it alone
    // -------------------------------------------------------------------------
    nl_state_e r_nl_state;
    nl_state_e w_nl_next;
    logic      w_cap_x;
    logic      w_cap_y;
    logic      w_cap_t;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_nl_state <= NL_IDLE;
        end else begin
            r_nl_state <= w_nl_next;
        end
    end

    always_comb begin
        w_nl_next = r_nl_state;
        w_cap_x   = 1'b0;
        w_cap_y   = 1'b0;
        w_cap_t   = 1'b0;
        if (w_nl_req) begin
            w_nl_next = NL_IDLE;
            if (w_seq_int == NL_SEQ_X) begin
                w_cap_x   = 1'b1;
                w_nl_next = NL_X;
            end else if ((w_seq_int == NL_SEQ_Y) && (r_nl_state == NL_X)) begin
                w_cap_y   = 1'b1;
                w_nl_next = NL_Y;
            end else if ((w_seq_int == NL_SEQ_T) && (r_nl_state == NL_Y)) begin
                w_cap_t   = 1'b1;
                w_nl_next = NL_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            xk      <= '0;
            yk      <= '0;
            xita    <= '0;
            lkx     <= '0;
            lky     <= '0;
            nl_done <= 1'b0;
        end else begin
            nl_done <= w_cap_t;
            if (w_cap_x) begin
                xk <= w_cb_lane[0];
            end
            if (w_cap_y) begin
                yk  <= w_cb_lane[1];
                lkx <= w_lo;
            end
            if (w_cap_t) begin
                xita <= w_cb_lane[2];
                lky  <= w_hi;
            end
        end
    end

endmodule

// File: tb/tb_cb_douta_router.sv
// -----------------------------------------------------------------------------
// tb_cb_douta_router
//   Two router instances (L=4/RD_LAT=2 and L=8/RD_LAT=3) share clock and reset.
//   Directed requests push their hand-computed responses, tagged with the
//   cycle they must appear in, into a per-instance queue; a negedge monitor
//   pops one entry whenever an instance shows out_valid or nl_done and
//   compares every output bus. A small shift register stands in for the CB
//   memory, presenting each request's data RD_LAT cycles after issue.
// -----------------------------------------------------------------------------
module tb_cb_douta_router;
    import cb_map_pkg::*;

    localparam int DW  = 32;
    localparam int SQ  = 10;
    localparam int L0  = 4;
    localparam int RD0 = 2;
    localparam int LK0 = 1;
    localparam int L1  = 8;
    localparam int RD1 = 3;
    localparam int LK1 = 2;

    logic clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance 0 signals ----------------
    logic              v0;
    logic [2:0]        dst0;
    logic [1:0]        dir0;
    logic [LK0-1:0]    lk0;
    logic [SQ-1:0]     seq0;
    logic [L0*DW-1:0]  din0, cb0, a0, b0, m0, tb0;
    logic [3:0]        ov0;
    logic [DW-1:0]     xk0, yk0, xita0, lkx0, lky0;
    logic              nld0, se0;
    logic [L0*DW-1:0]  sr0 [RD0];

    // ---------------- instance 1 signals ----------------
    logic              v1;
    logic [2:0]        dst1;
    logic [1:0]        dir1;
    logic [LK1-1:0]    lk1;
    logic [SQ-1:0]     seq1;
    logic [L1*DW-1:0]  din1, cb1, a1, b1, m1, tb1;
    logic [3:0]        ov1;
    logic [DW-1:0]     xk1, yk1, xita1, lkx1, lky1;
    logic              nld1, se1;
    logic [L1*DW-1:0]  sr1 [RD1];

    // CB memory stand-in: data for a request appears RD_LAT cycles later
    always @(posedge clk) begin
        sr0[0] <= din0;
        for (int i = 1; i < RD0; i++) sr0[i] <= sr0[i-1];
        sr1[0] <= din1;
        for (int i = 1; i < RD1; i++) sr1[i] <= sr1[i-1];
    end
    assign cb0 = sr0[RD0-1];
    assign cb1 = sr1[RD1-1];

    cb_douta_router #(.L(L0), .RSA_DW(DW), .SEQ_CNT_DW(SQ), .RD_LAT(RD0)) u_dut0 (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .req_valid(v0), .req_dst(dst0), .req_dir(dir0), .req_lk(lk0), .req_seq(seq0),
        .CB_douta(cb0),
        .A_douta(a0), .B_douta(b0), .M_douta(m0), .TB_douta(tb0), .out_valid(ov0),
        .xk(xk0), .yk(yk0), .xita(xita0), .lkx(lkx0), .lky(lky0),
        .nl_done(nld0), .sel_err(se0)
    );

    cb_douta_router #(.L(L1), .RSA_DW(DW), .SEQ_CNT_DW(SQ), .RD_LAT(RD1)) u_dut1 (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .req_valid(v1), .req_dst(dst1), .req_dir(dir1), .req_lk(lk1), .req_seq(seq1),
        .CB_douta(cb1),
        .A_douta(a1), .B_douta(b1), .M_douta(m1), .TB_douta(tb1), .out_valid(ov1),
        .xk(xk1), .yk(yk1), .xita(xita1), .lkx(lkx1), .lky(lky1),
        .nl_done(nld1), .sel_err(se1)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int           cyc;
        logic [3:0]   ov;
        logic [255:0] a, b, m, tb;
        logic         nl;
        logic [31:0]  xk, yk, xita, lkx, lky;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [127:0] l4(input int x0, x1, x2, x3);
        return {x3, x2, x1, x0};
    endfunction

    function automatic logic [255:0] l8(input int x0, x1, x2, x3, x4, x5, x6, x7);
        return {x7, x6, x5, x4, x3, x2, x1, x0};
    endfunction

    task automatic push(input int which, input logic [3:0] ov,
                        input logic [255:0] a, b, m, tb);
        exp_t e;
        e.cyc = cyc + ((which == 0) ? RD0 : RD1) + 1;
        e.ov = ov; e.a = a; e.b = b; e.m = m; e.tb = tb;
        e.nl = 1'b0; e.xk = '0; e.yk = '0; e.xita = '0; e.lkx = '0; e.lky = '0;
        if (which == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic push_nl(input int which, input logic [31:0] xk, yk, xita, lkx, lky);
        exp_t e;
        e.cyc = cyc + ((which == 0) ? RD0 : RD1) + 1;
        e.ov = '0; e.a = '0; e.b = '0; e.m = '0; e.tb = '0;
        e.nl = 1'b1; e.xk = xk; e.yk = yk; e.xita = xita; e.lkx = lkx; e.lky = lky;
        if (which == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic mon(input int which, input logic [3:0] ov,
                       input logic [255:0] a, b, m, tb, input logic nl,
                       input logic [31:0] xk, yk, xita, lkx, lky);
        exp_t  e;
        string p;
        p = $sformatf("dut%0d", which);
        if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_unexpected_output: out_valid=%b nl_done=%b at cycle %0d, required no output",
                     p, ov, nl, cyc);
        end else begin
            if (which == 0) e = q0.pop_front(); else e = q1.pop_front();
            check({p, "_latency_cycle"}, cyc, e.cyc);
            check({p, "_out_valid"}, ov, e.ov);
            check({p, "_A_douta"}, a, e.a);
            check({p, "_B_douta"}, b, e.b);
            check({p, "_M_douta"}, m, e.m);
            check({p, "_TB_douta"}, tb, e.tb);
            check({p, "_nl_done"}, nl, e.nl);
            if (e.nl) begin
                check({p, "_xk"}, xk, e.xk);
                check({p, "_yk"}, yk, e.yk);
                check({p, "_xita"}, xita, e.xita);
                check({p, "_lkx"}, lkx, e.lkx);
                check({p, "_lky"}, lky, e.lky);
            end
        end
    endtask

    always @(negedge clk) begin
        if (sys_rst_n && (ov0 != 4'd0 || nld0))
            mon(0, ov0, a0, b0, m0, tb0, nld0, xk0, yk0, xita0, lkx0, lky0);
        if (sys_rst_n && (ov1 != 4'd0 || nld1))
            mon(1, ov1, a1, b1, m1, tb1, nld1, xk1, yk1, xita1, lkx1, lky1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send0(input logic [2:0] d, input logic [1:0] r, input int lk,
                         input int s, input logic [L0*DW-1:0] data);
        @(posedge clk); #1;
        v0 = 1'b1; dst0 = d; dir0 = r; lk0 = LK0'(lk); seq0 = SQ'(s); din0 = data;
    endtask

    task automatic send1(input logic [2:0] d, input logic [1:0] r, input int lk,
                         input int s, input logic [L1*DW-1:0] data);
        @(posedge clk); #1;
        v1 = 1'b1; dst1 = d; dir1 = r; lk1 = LK1'(lk); seq1 = SQ'(s); din1 = data;
    endtask

    task automatic idle_all();
        @(posedge clk); #1;
        v0 = 1'b0; dst0 = '0; dir0 = '0; lk0 = '0; seq0 = '0; din0 = '0;
        v1 = 1'b0; dst1 = '0; dir1 = '0; lk1 = '0; seq1 = '0; din1 = '0;
    endtask

    task automatic drain(input int which);
        int left;
        for (int i = 0; i < 40; i++) begin
            left = (which == 0) ? q0.size() : q1.size();
            if (left == 0) break;
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        left = (which == 0) ? q0.size() : q1.size();
        check($sformatf("dut%0d_pending_responses", which), left, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed test sequence ----------------
    initial begin
        logic [127:0] d4;
        logic [127:0] d4b;
        logic [255:0] d8;
        logic [127:0] tb_tab [6];

        d4  = l4(10, 20, 30, 40);
        d4b = l4(50, 60, 70, 80);
        d8  = l8(10, 20, 30, 40, 50, 60, 70, 80);
        tb_tab[0] = l4(0, 0, 0, 40);
        tb_tab[1] = l4(30, 0, 0, 0);
        tb_tab[2] = l4(40, 30, 0, 0);
        tb_tab[3] = l4(0, 40, 30, 0);
        tb_tab[4] = l4(0, 0, 40, 30);
        tb_tab[5] = '0;

        v0 = 1'b0; dst0 = '0; dir0 = '0; lk0 = '0; seq0 = '0; din0 = '0;
        v1 = 1'b0; dst1 = '0; dir1 = '0; lk1 = '0; seq1 = '0; din1 = '0;
        sys_rst_n = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_A_douta0", a0, '0);
        check("rst_TB_douta0", tb0, '0);
        check("rst_out_valid0", ov0, '0);
        check("rst_xk0", xk0, '0);
        check("rst_nl_done0", nld0, '0);
        check("rst_sel_err0", se0, '0);
        check("rst_out_valid1", ov1, '0);
        check("rst_sel_err1", se1, '0);
        @(posedge clk); #1;
        sys_rst_n = 1'b1;

        // A/B/M mappings, back to back
        send0(DST_A, DIR_NEG, 1, 0, d4);  push(0, 4'b0001, l4(40, 30, 20, 10), '0, '0, '0);
        send0(DST_B, DIR_POS, 1, 0, d4);  push(0, 4'b0010, '0, d4, '0, '0);
        send0(DST_M, DIR_NEW, 1, 0, d4);  push(0, 4'b0100, '0, '0, l4(10, 20, 0, 0), '0);
        send0(DST_M, DIR_NEW, 2, 0, d4);  push(0, 4'b0100, '0, '0, l4(30, 40, 0, 0), '0);
        send0(DST_A, DIR_IDLE, 1, 0, d4); push(0, 4'b0001, '0, '0, '0, '0);

        // TB walk, lk=2, seq 0..5 back to back, then a non-NEW TB request
        for (int s = 0; s < 6; s++) begin
            send0(DST_TB, DIR_NEW, 2, s, d4);
            push(0, 4'b1000, '0, '0, '0, tb_tab[s]);
        end
        send0(DST_TB, DIR_POS, 2, 2, d4); push(0, 4'b1000, '0, '0, '0, '0);
        send0(DST_IDLE, DIR_POS, 1, 0, d4);

        // NL capture 3,4,5 with lk=1
        send0(DST_NL, DIR_NEW, 1, 3, d4);
        send0(DST_NL, DIR_NEW, 1, 4, d4);
        send0(DST_NL, DIR_NEW, 1, 5, d4);
        push_nl(0, 32'd10, 32'd20, 32'd30, 32'd10, 32'd20);
        idle_all();
        drain(0);

        // Out of order 3,5: xk updates, xita/lky hold, no nl_done
        send0(DST_NL, DIR_NEW, 1, 3, d4b);
        send0(DST_NL, DIR_NEW, 1, 5, d4b);
        idle_all();
        drain(0);
        check("ooo_xk0", xk0, 32'd50);
        check("ooo_xita0_hold", xita0, 32'd30);
        check("ooo_lky0_hold", lky0, 32'd20);
        check("ooo_yk0_hold", yk0, 32'd20);

        // Reset between seq 4 and seq 5 while seq 4 is still in flight
        send0(DST_NL, DIR_NEW, 1, 3, d4);
        send0(DST_NL, DIR_NEW, 1, 4, d4);
        idle_all();
        sys_rst_n = 1'b0;
        @(negedge clk);
        check("midrst_A_douta0", a0, '0);
        check("midrst_M_douta0", m0, '0);
        check("midrst_out_valid0", ov0, '0);
        check("midrst_xk0", xk0, '0);
        check("midrst_yk0", yk0, '0);
        check("midrst_xita0", xita0, '0);
        check("midrst_lkx0", lkx0, '0);
        check("midrst_lky0", lky0, '0);
        check("midrst_nl_done0", nld0, '0);
        @(posedge clk); #1;
        sys_rst_n = 1'b1;
        send0(DST_NL, DIR_NEW, 1, 5, d4);
        idle_all();
        drain(0);
        check("postrst_xita0", xita0, '0);
        check("postrst_lky0", lky0, '0);
        check("postrst_yk0", yk0, '0);

        // Reserved destination: no outputs, sticky sel_err
        send0(3'b101, DIR_POS, 1, 0, d4);
        idle_all();
        drain(0);
        check("rsv_sel_err0", se0, 1'b1);
        send0(DST_A, DIR_POS, 1, 0, d4); push(0, 4'b0001, d4, '0, '0, '0);
        idle_all();
        drain(0);
        check("rsv_sel_err0_sticky", se0, 1'b1);
        check("rsv_sel_err1_clear", se1, 1'b0);

        // Instance 1: L=8, RD_LAT=3
        send1(DST_A, DIR_NEG, 1, 0, d8);
        push(1, 4'b0001, l8(80, 70, 60, 50, 40, 30, 20, 10), '0, '0, '0);
        send1(DST_B, DIR_NEW, 1, 0, d8); push(1, 4'b0010, '0, l8(10, 20, 0, 0, 0, 0, 0, 0), '0, '0);
        send1(DST_B, DIR_NEW, 3, 0, d8); push(1, 4'b0010, '0, l8(50, 60, 0, 0, 0, 0, 0, 0), '0, '0);
        send1(DST_B, DIR_NEW, 0, 0, d8); push(1, 4'b0010, '0, l8(70, 80, 0, 0, 0, 0, 0, 0), '0, '0);
        send1(DST_TB, DIR_NEW, 1, 0, d8); push(1, 4'b1000, '0, '0, '0, l8(0, 0, 0, 0, 0, 0, 0, 20));
        send1(DST_TB, DIR_NEW, 1, 1, d8); push(1, 4'b1000, '0, '0, '0, l8(10, 0, 0, 0, 0, 0, 0, 0));
        send1(DST_TB, DIR_NEW, 1, 8, d8); push(1, 4'b1000, '0, '0, '0, l8(0, 0, 0, 0, 0, 0, 20, 10));
        send1(DST_TB, DIR_NEW, 1, 9, d8); push(1, 4'b1000, '0, '0, '0, '0);
        send1(3'b110, DIR_NEW, 1, 0, d8);
        idle_all();
        drain(1);
        check("rsv_sel_err1", se1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
